// File: rtl/seq_mac_neuron_if.sv
// rtl/seq_mac_neuron_if.sv - activation-in / result-out handshake bundle for seq_mac_neuron
interface seq_mac_neuron_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_mac_neuron.sv
// rtl/seq_mac_neuron.sv - sequential fixed-point MAC neuron with ReLU, optional NEURON_SATURATE_EN clamp
module seq_mac_neuron #(
    parameter int INPUT_COUNT = 4,
    parameter int DATA_W      = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_W       = 40,
    parameter logic signed [DATA_W-1:0] WEIGHTS [INPUT_COUNT] = '{default: 0},
    parameter logic signed [DATA_W-1:0] BIAS = '0
) (
    input logic              clk,
    input logic              rst,
    seq_mac_neuron_if.slave  bus
);
    localparam int IDX_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_COUNT - 1);

    // Bias is aligned to the product's 2*FRAC_BITS scale so the final shift treats both alike.
    localparam logic signed [ACC_W-1:0] BIAS_EXT = ACC_W'(BIAS);
    localparam logic signed [ACC_W-1:0] ACC_INIT = BIAS_EXT <<< FRAC_BITS;

    typedef enum logic {
        ST_ACCUM,
        ST_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     busy_q, busy_d;

    logic                       in_ready_c;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    final_val;
    logic signed [DATA_W-1:0]   activated;

    always_comb begin
        prod      = bus.in_data * WEIGHTS[idx_q];
        acc_sum   = acc_q + ACC_W'(prod);
        final_val = acc_sum >>> FRAC_BITS;
    end

`ifdef NEURON_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});

    always_comb begin
        activated = DATA_W'(final_val);
        if (final_val < 0) begin
            activated = '0;
        end else if (final_val > MAX_POS) begin
            activated = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    // Positive results wider than DATA_W keep only their low bits and may read as negative.
    always_comb begin
        activated = DATA_W'(final_val);
        if (final_val < 0) begin
            activated = '0;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        in_ready_c  = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    busy_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_data_d  = activated;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        acc_d = acc_sum;
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    acc_d       = ACC_INIT;
                    busy_d      = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            idx_q       <= '0;
            acc_q       <= ACC_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_mac_neuron.sv
// tb/tb_seq_mac_neuron.sv - self-checking bench: six weight/bias builds driven in lockstep against a reference model
module tb_seq_mac_neuron;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic [15:0] od [6];
    logic        ov [6];
    logic        ir [6];
    logic        bz [6];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    seq_mac_neuron_if #(.DATA_W(16)) bus0 ();
    seq_mac_neuron_if #(.DATA_W(16)) bus1 ();
    seq_mac_neuron_if #(.DATA_W(16)) bus2 ();
    seq_mac_neuron_if #(.DATA_W(16)) bus3 ();
    seq_mac_neuron_if #(.DATA_W(16)) bus4 ();
    seq_mac_neuron_if #(.DATA_W(16)) bus5 ();

    assign bus0.in_valid = in_valid; assign bus0.in_data = in_data; assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid; assign bus1.in_data = in_data; assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid; assign bus2.in_data = in_data; assign bus2.out_ready = out_ready;
    assign bus3.in_valid = in_valid; assign bus3.in_data = in_data; assign bus3.out_ready = out_ready;
    assign bus4.in_valid = in_valid; assign bus4.in_data = in_data; assign bus4.out_ready = out_ready;
    assign bus5.in_valid = in_valid; assign bus5.in_data = in_data; assign bus5.out_ready = out_ready;

    assign od[0] = bus0.out_data; assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready; assign bz[0] = bus0.busy;
    assign od[1] = bus1.out_data; assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready; assign bz[1] = bus1.busy;
    assign od[2] = bus2.out_data; assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready; assign bz[2] = bus2.busy;
    assign od[3] = bus3.out_data; assign ov[3] = bus3.out_valid; assign ir[3] = bus3.in_ready; assign bz[3] = bus3.busy;
    assign od[4] = bus4.out_data; assign ov[4] = bus4.out_valid; assign ir[4] = bus4.in_ready; assign bz[4] = bus4.busy;
    assign od[5] = bus5.out_data; assign ov[5] = bus5.out_valid; assign ir[5] = bus5.in_ready; assign bz[5] = bus5.busy;

    seq_mac_neuron #(.WEIGHTS('{16'sd256, 16'sd512, -16'sd256, 16'sd0}), .BIAS(16'sd0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_mac_neuron #(.WEIGHTS('{-16'sd256, -16'sd256, -16'sd256, -16'sd256}), .BIAS(16'sd0))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_mac_neuron #(.WEIGHTS('{16'sd0, 16'sd0, 16'sd0, 16'sd0}), .BIAS(-16'sd128))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    seq_mac_neuron #(.WEIGHTS('{16'sd0, 16'sd0, 16'sd0, 16'sd0}), .BIAS(16'sd300))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    seq_mac_neuron #(.WEIGHTS('{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}), .BIAS(16'sd0))
        u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_mac_neuron #(.WEIGHTS('{16'sd100, -16'sd300, 16'sd77, -16'sd5}), .BIAS(16'sd50))
        u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int wt [6][4] = '{'{256, 512, -256, 0}, '{-256, -256, -256, -256}, '{0, 0, 0, 0},
                      '{0, 0, 0, 0}, '{32767, 32767, 32767, 32767}, '{100, -300, 77, -5}};
    int bs [6]    = '{0, 0, -128, 300, 0, 50};

    typedef struct packed {
        logic [3:0][15:0] din;
        logic [5:0][31:0] fin;
        logic             gaps;
        logic [7:0]       hold;
    } vec_t;

    vec_t tbl [3];

    function automatic longint model_final(input int k, input logic [3:0][15:0] din);
        longint s;
        s = longint'(bs[k]) * 256;
        for (int i = 0; i < 4; i++) s += longint'($signed(din[i])) * longint'(wt[k][i]);
        return s >>> 8;
    endfunction

    function automatic logic [15:0] narrow(input longint f);
        if (f < 0) return 16'h0000;
`ifdef NEURON_SATURATE_EN
        if (f > 32767) return 16'h7FFF;
`endif
        return f[15:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!ir[0] && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("beat_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [3:0][15:0] din, input bit gaps,
                             input int hold, input logic [5:0][15:0] exp);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                tick();
                chk({tag, "_gap_no_output"}, ov[0], 0);
            end
            beat(din[i]);
            if (i == 0) chk({tag, "_busy_after_first"}, bz[0], 1);
        end
        chk({tag, "_valid_latency"}, ov[0], 1);
        chk({tag, "_in_ready_out"}, ir[0], 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            tick();
            chk({tag, "_hold_valid"}, ov[0], 1);
            chk({tag, "_hold_data"}, od[0], exp[0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) chk($sformatf("%s_data_dut%0d", tag, k), od[k], exp[k]);
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, ov[0], 0);
        chk({tag, "_busy_drop"}, bz[0], 0);
        chk({tag, "_ready_back"}, ir[0], 1);
        chk({tag, "_data_kept"}, od[0], exp[0]);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0][15:0] exp;
        logic [3:0][15:0] rdin;

        tbl[0] = '{din: {4{16'd256}},
                   fin: {32'(-78), 32'(131068), 32'(300), 32'(-128), 32'(-1024), 32'(512)},
                   gaps: 1'b0, hold: 8'd0};
        tbl[1] = '{din: {4{16'd32767}},
                   fin: {32'(-16334), 32'(16776192), 32'(300), 32'(-128), 32'(-131068), 32'(65534)},
                   gaps: 1'b1, hold: 8'd3};
        tbl[2] = '{din: {16'd9, 16'hFF00, 16'd256, 16'd1024},
                   fin: {32'(72), 32'(132219), 32'(300), 32'(-128), 32'(-1033), 32'(1792)},
                   gaps: 1'b0, hold: 8'd1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("reset_out_data%0d", k), od[k], 0);
            chk($sformatf("reset_out_valid%0d", k), ov[k], 0);
        end
        chk("reset_busy", bz[0], 0);
        chk("reset_in_ready", ir[0], 1);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 6; k++) exp[k] = narrow(longint'($signed(tbl[t].fin[k])));
            run_frame($sformatf("tbl%0d", t), tbl[t].din, tbl[t].gaps, int'(tbl[t].hold), exp);
        end

        // reset in the middle of a frame must leave no residue in the accumulator
        beat(16'd256);
        beat(16'd256);
        chk("midrst_busy_pre", bz[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", bz[0], 0);
        chk("midrst_in_ready", ir[0], 1);
        chk("midrst_out_valid", ov[0], 0);
        for (int k = 0; k < 6; k++) exp[k] = narrow(longint'($signed(tbl[0].fin[k])));
        run_frame("midrst_frame", tbl[0].din, 1'b0, 0, exp);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) rdin[i] = 16'($urandom);
            if (r % 5 == 0) rdin = {4{16'h8000}};
            for (int k = 0; k < 6; k++) exp[k] = narrow(model_final(k, rdin));
            run_frame($sformatf("rnd%0d", r), rdin, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
